control_funcion_conf: RTL and testbench



---
 rtl/conf_pkg.sv | 40 ++++
 rtl/contador_inactividad.sv | 36 +++
 rtl/control_funcion_conf.sv | 106 ++++++++++
 tb/tb_control_funcion_conf.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/conf_pkg.sv
// Shared constants for the configuration-mode controller and the chip-select decoder.
// Mode codes double as the controller's FSM state encoding.
package conf_pkg;

  localparam logic [2:0] FUNC_IDLE  = 3'b000;
  localparam logic [2:0] FUNC_HORA  = 3'b001;
  localparam logic [2:0] FUNC_FECHA = 3'b010;
  localparam logic [2:0] FUNC_TIMER = 3'b100;

  localparam logic [1:0] CAMPO_0 = 2'd0;
  localparam logic [1:0] CAMPO_1 = 2'd1;
  localparam logic [1:0] CAMPO_2 = 2'd2;

  localparam int TIMEOUT_SEG_DEF = 30;

  typedef enum logic [2:0] {
    ST_IDLE  = FUNC_IDLE,
    ST_HORA  = FUNC_HORA,
    ST_FECHA = FUNC_FECHA,
    ST_TIMER = FUNC_TIMER
  } conf_state_e;

  // Cursor wraps over three fields; an out-of-range value rejoins at field 0.
  function automatic logic [1:0] campo_up(input logic [1:0] c);
    case (c)
      CAMPO_0: campo_up = CAMPO_1;
      CAMPO_1: campo_up = CAMPO_2;
      default: campo_up = CAMPO_0;
    endcase
  endfunction

  function automatic logic [1:0] campo_down(input logic [1:0] c);
    case (c)
      CAMPO_0: campo_down = CAMPO_2;
      CAMPO_2: campo_down = CAMPO_1;
      default: campo_down = CAMPO_0;
    endcase
  endfunction

endpackage

// File: rtl/contador_inactividad.sv
// Inactivity second counter: expira fires on the tick that completes TIMEOUT_SEG
// idle seconds; the count restarts after expiry.
module contador_inactividad #(
  parameter int TO_W        = 6,
  parameter int TIMEOUT_SEG = 30
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  input  logic tick,
  output logic expira
);

  localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_SEG - 1);

  logic [TO_W-1:0] cnt_q, cnt_d;

  // Not gated by clr: the owner decides whether a same-cycle button cancels it.
  assign expira = en & tick & (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr || !en) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = expira ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/control_funcion_conf.sv
// Configuration-mode controller: turns button pulses into the decoder mode code,
// field cursor, countdown run/stop and alarm state, with an inactivity return to idle.
module control_funcion_conf
  import conf_pkg::*;
#(
  parameter int TIMEOUT_SEG = TIMEOUT_SEG_DEF,
  parameter int TO_W        = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_modo,
  input  logic       btn_timer,
  input  logic       btn_izq,
  input  logic       btn_der,
  input  logic       tick_1hz,
  input  logic       fin_timer,
  output logic [2:0] funcion_conf,
  output logic       flag_mostrar_count,
  output logic [1:0] campo_sel,
  output logic       timer_activo,
  output logic       alarma
);

  conf_state_e state_q, state_d;
  logic [1:0]  campo_q, campo_d;
  logic        tact_q, tact_d;
  logic        alarm_q, alarm_d;
  logic        flag_q, flag_d;
  logic        any_btn, expira;

  assign any_btn = btn_modo | btn_timer | btn_izq | btn_der;

  contador_inactividad #(
    .TO_W       (TO_W),
    .TIMEOUT_SEG(TIMEOUT_SEG)
  ) u_inact (
    .clk   (clk),
    .reset (reset),
    .clr   (any_btn | (state_d != state_q)),
    .en    (state_q != ST_IDLE),
    .tick  (tick_1hz),
    .expira(expira)
  );

  always_comb begin
    state_d = state_q;
    campo_d = campo_q;
    tact_d  = tact_q;
    alarm_d = alarm_q;

    if (fin_timer && tact_q) begin
      tact_d  = 1'b0;
      alarm_d = 1'b1;
    end else if (alarm_q && any_btn) begin
      alarm_d = 1'b0;
    end else if (btn_modo) begin
      case (state_q)
        ST_IDLE:  state_d = ST_HORA;
        ST_HORA:  state_d = ST_FECHA;
        ST_FECHA: state_d = ST_TIMER;
        default:  state_d = ST_IDLE;
      endcase
      campo_d = CAMPO_0;
      if (state_d == ST_TIMER) tact_d = 1'b0;
    end else if (any_btn) begin
      if (state_q == ST_IDLE) begin
        if (btn_timer) tact_d = ~tact_q;
      end else if (btn_der && !btn_izq) begin
        campo_d = campo_up(campo_q);
      end else if (btn_izq && !btn_der) begin
        campo_d = campo_down(campo_q);
      end
    end else if (expira) begin
      state_d = ST_IDLE;
    end

    // Unused codes fall back to idle; the cursor is parked whenever idle.
    if (!(state_q inside {ST_IDLE, ST_HORA, ST_FECHA, ST_TIMER})) state_d = ST_IDLE;
    if (state_d == ST_IDLE) campo_d = CAMPO_0;

    flag_d = tact_d | alarm_d | (state_d == ST_TIMER);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      campo_q <= CAMPO_0;
      tact_q  <= 1'b0;
      alarm_q <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      campo_q <= campo_d;
      tact_q  <= tact_d;
      alarm_q <= alarm_d;
      flag_q  <= flag_d;
    end
  end

  assign funcion_conf       = state_q;
  assign flag_mostrar_count = flag_q;
  assign campo_sel          = campo_q;
  assign timer_activo       = tact_q;
  assign alarma             = alarm_q;

endmodule

// File: tb/tb_control_funcion_conf.sv
// Bench for control_funcion_conf: directed scenario tables plus a randomized run
// against a behavioural model of the controller.
module tb_control_funcion_conf;

  localparam int TO = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_modo = 1'b0, btn_timer = 1'b0, btn_izq = 1'b0, btn_der = 1'b0;
  logic       tick_1hz = 1'b0, fin_timer = 1'b0;
  logic [2:0] funcion_conf;
  logic       flag_mostrar_count;
  logic [1:0] campo_sel;
  logic       timer_activo;
  logic       alarma;

  int errors = 0;
  int checks = 0;

  // Model state: mode index 0..3 (idle, hora, fecha, timer), cursor 0..2.
  int m_mode = 0, m_cur = 0, m_tact = 0, m_alarm = 0, m_cnt = 0;

  control_funcion_conf #(.TIMEOUT_SEG(TO), .TO_W(6)) dut (
    .clk               (clk),
    .reset             (reset),
    .btn_modo          (btn_modo),
    .btn_timer         (btn_timer),
    .btn_izq           (btn_izq),
    .btn_der           (btn_der),
    .tick_1hz          (tick_1hz),
    .fin_timer         (fin_timer),
    .funcion_conf      (funcion_conf),
    .flag_mostrar_count(flag_mostrar_count),
    .campo_sel         (campo_sel),
    .timer_activo      (timer_activo),
    .alarma            (alarma)
  );

  always #5 clk = ~clk;

  // Stimulus vector bits: {reset, modo, timer, izq, der, tick, fin}
  // Observed vector bits: {funcion_conf[2:0], flag, campo_sel[1:0], timer_activo, alarma}
  function automatic logic [7:0] dut_vec();
    return {funcion_conf, flag_mostrar_count, campo_sel, timer_activo, alarma};
  endfunction

  function automatic logic [7:0] model_vec();
    logic [2:0] code;
    logic       flag;
    case (m_mode)
      1:       code = 3'b001;
      2:       code = 3'b010;
      3:       code = 3'b100;
      default: code = 3'b000;
    endcase
    flag = (m_tact != 0) || (m_alarm != 0) || (m_mode == 3);
    return {code, flag, 2'(m_cur), m_tact[0], m_alarm[0]};
  endfunction

  task automatic model_step(input logic [6:0] s);
    logic r, m, t, l, d, k, f, any, expired;
    int old;
    {r, m, t, l, d, k, f} = s;
    if (r) begin
      m_mode = 0; m_cur = 0; m_tact = 0; m_alarm = 0; m_cnt = 0;
      return;
    end
    any = m | t | l | d;
    old = m_mode;
    expired = (m_mode != 0) && !any && k && (m_cnt + 1 == TO);
    if (f && m_tact != 0) begin
      m_tact = 0; m_alarm = 1;
    end else if (m_alarm != 0 && any) begin
      m_alarm = 0;
    end else if (m) begin
      m_mode = (m_mode + 1) % 4;
      m_cur = 0;
      if (m_mode == 3) m_tact = 0;
    end else if (any) begin
      if (m_mode == 0) begin
        if (t) m_tact = 1 - m_tact;
      end else if (d && !l) begin
        m_cur = (m_cur + 1) % 3;
      end else if (l && !d) begin
        m_cur = (m_cur + 2) % 3;
      end
    end else if (expired) begin
      m_mode = 0; m_cur = 0;
    end
    if (old == 0 || any || m_mode != old) m_cnt = 0;
    else if (k) m_cnt = expired ? 0 : m_cnt + 1;
  endtask

  // One clock of stimulus; outputs are stable and ready to sample when this returns.
  task automatic drive(input logic [6:0] s);
    @(negedge clk);
    {reset, btn_modo, btn_timer, btn_izq, btn_der, tick_1hz, fin_timer} = s;
    @(posedge clk);
    model_step(s);
    #1;
    {reset, btn_modo, btn_timer, btn_izq, btn_der, tick_1hz, fin_timer} = 7'd0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive({1'b1, 6'($urandom_range(0, 63))});
      checks++;
      if (dut_vec() !== 8'h00) begin
        errors++;
        $display("FAIL reset step %0d: got %h want 00", i, dut_vec());
      end
    end
  endtask

  task automatic test_mode_cycle();
    logic [6:0] st [5] = '{7'h00, 7'h20, 7'h20, 7'h20, 7'h20};
    logic [7:0] ex [5] = '{8'h00, 8'h20, 8'h40, 8'h90, 8'h00};
    for (int i = 0; i < 5; i++) begin
      drive(st[i]);
      checks++;
      if (dut_vec() !== ex[i]) begin
        errors++;
        $display("FAIL mode_cycle step %0d: got %h want %h", i, dut_vec(), ex[i]);
      end
    end
  endtask

  task automatic test_cursor();
    logic [6:0] st [6] = '{7'h20, 7'h08, 7'h04, 7'h04, 7'h0C, 7'h20};
    logic [7:0] ex [6] = '{8'h20, 8'h28, 8'h20, 8'h24, 8'h24, 8'h40};
    for (int i = 0; i < 6; i++) begin
      drive(st[i]);
      checks++;
      if (dut_vec() !== ex[i]) begin
        errors++;
        $display("FAIL cursor step %0d: got %h want %h", i, dut_vec(), ex[i]);
      end
    end
  endtask

  task automatic test_timeout();
    logic [6:0] st [12] = '{7'h02, 7'h00, 7'h02, 7'h02, 7'h20, 7'h20,
                           7'h02, 7'h02, 7'h06, 7'h02, 7'h02, 7'h02};
    logic [7:0] ex [12] = '{8'h40, 8'h40, 8'h40, 8'h00, 8'h20, 8'h40,
                           8'h40, 8'h40, 8'h44, 8'h44, 8'h44, 8'h00};
    for (int i = 0; i < 12; i++) begin
      drive(st[i]);
      checks++;
      if (dut_vec() !== ex[i]) begin
        errors++;
        $display("FAIL timeout step %0d: got %h want %h", i, dut_vec(), ex[i]);
      end
    end
  endtask

  task automatic test_timer_alarm();
    logic [6:0] st [4] = '{7'h10, 7'h11, 7'h20, 7'h20};
    logic [7:0] ex [4] = '{8'h12, 8'h11, 8'h00, 8'h20};
    for (int i = 0; i < 4; i++) begin
      drive(st[i]);
      checks++;
      if (dut_vec() !== ex[i]) begin
        errors++;
        $display("FAIL timer_alarm step %0d: got %h want %h", i, dut_vec(), ex[i]);
      end
    end
  endtask

  task automatic test_conf_timer();
    logic [6:0] st [10] = '{7'h20, 7'h20, 7'h20, 7'h10, 7'h20,
                           7'h20, 7'h20, 7'h10, 7'h01, 7'h08};
    logic [7:0] ex [10] = '{8'h40, 8'h90, 8'h00, 8'h12, 8'h32,
                           8'h52, 8'h90, 8'h90, 8'h90, 8'h98};
    for (int i = 0; i < 10; i++) begin
      drive(st[i]);
      checks++;
      if (dut_vec() !== ex[i]) begin
        errors++;
        $display("FAIL conf_timer step %0d: got %h want %h", i, dut_vec(), ex[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [6:0] st [10] = '{7'h60, 7'h5A, 7'h00, 7'h10, 7'h20,
                           7'h20, 7'h04, 7'h01, 7'h45, 7'h00};
    logic [7:0] ex [10] = '{8'h00, 8'h00, 8'h00, 8'h12, 8'h32,
                           8'h52, 8'h56, 8'h55, 8'h00, 8'h00};
    for (int i = 0; i < 10; i++) begin
      drive(st[i]);
      checks++;
      if (dut_vec() !== ex[i]) begin
        errors++;
        $display("FAIL reset_mid step %0d: got %h want %h", i, dut_vec(), ex[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [6:0] s;
    drive(7'h40);
    for (int i = 0; i < 800; i++) begin
      s = {($urandom_range(0, 99) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 9) == 0)};
      drive(s);
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++;
        $display("FAIL random cycle %0d stim %b: got %h want %h", i, s, dut_vec(), model_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_mode_cycle();
    test_cursor();
    test_timeout();
    test_timer_alarm();
    test_conf_timer();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
